// File: rtl/ika87ad_intc_if.sv
// Core-side handshake of the interrupt controller: enables, ack strobes and the
// registered request/code returned to the interrupt sequencer.
interface ika87ad_intc_if #(
    parameter int CODEW = 5
);
    logic             i_INT_EN;
    logic             i_MULTI_IRQ_ENABLED;
    logic             i_MANUAL_ACK;
    logic [CODEW-1:0] i_ACK_CODE;
    logic             i_VEC_ACK;
    logic             o_INT_REQ;
    logic [CODEW-1:0] o_INT_CODE;

    modport master (
        output i_INT_EN, i_MULTI_IRQ_ENABLED, i_MANUAL_ACK, i_ACK_CODE, i_VEC_ACK,
        input  o_INT_REQ, o_INT_CODE
    );

    modport slave (
        input  i_INT_EN, i_MULTI_IRQ_ENABLED, i_MANUAL_ACK, i_ACK_CODE, i_VEC_ACK,
        output o_INT_REQ, o_INT_CODE
    );
endinterface

// File: rtl/ika87ad_intc.sv
// N-channel interrupt flag bank: edge/level capture, masking, fixed-priority
// arbitration (lowest index wins) and a vector-request handshake toward the core.
module ika87ad_intc #(
    parameter int NCH       = 8,
    parameter int CODEW     = 5,
    parameter int CODE_BASE = 0
) (
    input  logic              i_EMUCLK,
    input  logic              i_MRST_n,
    input  logic              i_TICK,
    input  logic [NCH-1:0]    i_IRQ,
    input  logic [NCH-1:0]    i_EDGE_MODE,
    input  logic [NCH-1:0]    i_MASK,
    output logic [NCH-1:0]    o_IFLAG,
    ika87ad_intc_if.slave     core
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [CODEW-1:0] code_of(input int idx);
        return CODEW'(CODE_BASE + idx);
    endfunction

    state_t           state_r;
    logic [NCH-1:0]   prev_r;
    logic [NCH-1:0]   flag_r;
    logic [CHW-1:0]   chan_r;
    logic [CODEW-1:0] code_r;
    logic             req_r;

    logic [NCH-1:0]   set_s;
    logic [NCH-1:0]   man_clr_s;
    logic [NCH-1:0]   auto_clr_s;
    logic [NCH-1:0]   flag_nxt_s;
    logic [NCH-1:0]   elig_s;
    logic [CHW-1:0]   win_s;
    logic             any_s;

    // Per-channel set/clear terms; a set always beats a same-tick clear.
    always_comb begin
        set_s      = {NCH{1'b0}};
        man_clr_s  = {NCH{1'b0}};
        auto_clr_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            set_s[i]      = i_EDGE_MODE[i] ? (i_IRQ[i] & ~prev_r[i]) : i_IRQ[i];
            man_clr_s[i]  = core.i_MULTI_IRQ_ENABLED & core.i_MANUAL_ACK & ~i_MASK[i]
                            & (core.i_ACK_CODE == code_of(i));
            auto_clr_s[i] = ~core.i_MULTI_IRQ_ENABLED & (state_r == ST_REQ)
                            & core.i_VEC_ACK & (chan_r == CHW'(i));
        end
        flag_nxt_s = set_s | (flag_r & ~(man_clr_s | auto_clr_s));
    end

    // Fixed-priority encoder: scanning downward leaves the lowest eligible index.
    always_comb begin
        elig_s = flag_r & ~i_MASK;
        any_s  = |elig_s;
        win_s  = {CHW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                win_s = CHW'(i);
            end else begin
                win_s = win_s;
            end
        end
    end

    // Flag bank and edge history, both frozen while the tick enable is low.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            prev_r <= {NCH{1'b0}};
            flag_r <= {NCH{1'b0}};
        end else if (i_TICK) begin
            prev_r <= i_IRQ;
            flag_r <= flag_nxt_s;
        end else begin
            prev_r <= prev_r;
            flag_r <= flag_r;
        end
    end

    // Request FSM; the code is latched on entry to REQ and never pre-empted there.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state_r <= ST_IDLE;
            chan_r  <= {CHW{1'b0}};
            code_r  <= {CODEW{1'b0}};
            req_r   <= 1'b0;
        end else if (i_TICK) begin
            case (state_r)
                ST_IDLE: begin
                    if (core.i_INT_EN && any_s) begin
                        state_r <= ST_REQ;
                        chan_r  <= win_s;
                        code_r  <= code_of(int'(win_s));
                        req_r   <= 1'b1;
                    end else begin
                        req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (core.i_VEC_ACK) begin
                        state_r <= ST_HOLD;
                        req_r   <= 1'b0;
                    end else if (!elig_s[chan_r] || !core.i_INT_EN) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        req_r   <= 1'b1;
                    end
                end
                // One quiet tick lets the core drop EI before re-arbitration.
                ST_HOLD: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
            req_r   <= req_r;
        end
    end

    assign o_IFLAG        = flag_r;
    assign core.o_INT_REQ  = req_r;
    assign core.o_INT_CODE = code_r;

endmodule

// File: tb/tb_ika87ad_intc.sv
// Directed bench for ika87ad_intc: linear stimulus with hand-computed expectations.
module tb_ika87ad_intc;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [7:0] irq;
    logic [7:0] edge_mode;
    logic [7:0] mask;
    logic [7:0] iflag;

    int n_cmp;
    int n_err;

    ika87ad_intc_if #(.CODEW(5)) core_if ();

    ika87ad_intc #(.NCH(8), .CODEW(5), .CODE_BASE(0)) dut (
        .i_EMUCLK    (clk),
        .i_MRST_n    (rst_n),
        .i_TICK      (tick),
        .i_IRQ       (irq),
        .i_EDGE_MODE (edge_mode),
        .i_MASK      (mask),
        .o_IFLAG     (iflag),
        .core        (core_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] f, input logic r, input logic [4:0] c);
        chk({tag, "_flag"}, {24'd0, iflag}, {24'd0, f});
        chk({tag, "_req"},  {31'd0, core_if.o_INT_REQ}, {31'd0, r});
        chk({tag, "_code"}, {27'd0, core_if.o_INT_CODE}, {27'd0, c});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        tick = 1'b1;
        irq = 8'h00;
        edge_mode = 8'hFF;
        mask = 8'h00;
        core_if.i_INT_EN = 1'b1;
        core_if.i_MULTI_IRQ_ENABLED = 1'b0;
        core_if.i_MANUAL_ACK = 1'b0;
        core_if.i_ACK_CODE = 5'd0;
        core_if.i_VEC_ACK = 1'b0;
        step();
        step();
        chk_state("reset", 8'h00, 1'b0, 5'd0);
        rst_n = 1'b1;
        step();

        // single edge channel 3, auto-ack
        irq = 8'h08; step();
        chk_state("t1_flag", 8'h08, 1'b0, 5'd0);
        irq = 8'h00; step();
        chk_state("t1_req", 8'h08, 1'b1, 5'd3);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t1_ack", 8'h00, 1'b0, 5'd3);
        core_if.i_VEC_ACK = 1'b0; step();
        chk_state("t1_hold", 8'h00, 1'b0, 5'd3);
        step();
        chk_state("t1_idle", 8'h00, 1'b0, 5'd3);

        // channels 5 and 2 together: 2 first
        irq = 8'h24; step();
        chk_state("t2_set", 8'h24, 1'b0, 5'd3);
        irq = 8'h00; step();
        chk_state("t2_req2", 8'h24, 1'b1, 5'd2);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t2_ack2", 8'h20, 1'b0, 5'd2);
        core_if.i_VEC_ACK = 1'b0; step();
        chk_state("t2_hold", 8'h20, 1'b0, 5'd2);
        step();
        chk_state("t2_req5", 8'h20, 1'b1, 5'd5);

        // channel 0 arrives during REQ of 5: no pre-emption
        irq = 8'h01; step();
        chk_state("t3_nopre", 8'h21, 1'b1, 5'd5);
        irq = 8'h00; step();
        chk_state("t3_hold5", 8'h21, 1'b1, 5'd5);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t3_ack5", 8'h01, 1'b0, 5'd5);
        core_if.i_VEC_ACK = 1'b0; step();
        step();
        chk_state("t3_req0", 8'h01, 1'b1, 5'd0);
        core_if.i_VEC_ACK = 1'b1; step();
        core_if.i_VEC_ACK = 1'b0; step();
        step();
        chk_state("t3_done", 8'h00, 1'b0, 5'd0);

        // multi-IRQ mode: vector fetch does not clear, manual ack does
        core_if.i_MULTI_IRQ_ENABLED = 1'b1;
        irq = 8'h42; step();
        chk_state("t4_set", 8'h42, 1'b0, 5'd0);
        irq = 8'h00; step();
        chk_state("t4_req1", 8'h42, 1'b1, 5'd1);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t4_vecack", 8'h42, 1'b0, 5'd1);
        core_if.i_VEC_ACK = 1'b0; step();
        step();
        chk_state("t4_rereq", 8'h42, 1'b1, 5'd1);
        core_if.i_MANUAL_ACK = 1'b1;
        core_if.i_ACK_CODE = 5'd20; step();
        chk_state("t4_nomatch", 8'h42, 1'b1, 5'd1);
        core_if.i_ACK_CODE = 5'd6;
        mask = 8'h40; step();
        chk_state("t4_masked", 8'h42, 1'b1, 5'd1);
        mask = 8'h00; step();
        chk_state("t4_man6", 8'h02, 1'b1, 5'd1);
        core_if.i_ACK_CODE = 5'd1; step();
        chk_state("t4_man1", 8'h00, 1'b1, 5'd1);
        core_if.i_MANUAL_ACK = 1'b0; step();
        chk_state("t4_withdraw", 8'h00, 1'b0, 5'd1);
        core_if.i_MULTI_IRQ_ENABLED = 1'b0;

        // new edge on latched channel in the auto-ack tick
        irq = 8'h10; step();
        irq = 8'h00; step();
        chk_state("t5_req4", 8'h10, 1'b1, 5'd4);
        irq = 8'h10;
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t5_setwins", 8'h10, 1'b0, 5'd4);
        irq = 8'h00;
        core_if.i_VEC_ACK = 1'b0; step();
        chk_state("t5_hold", 8'h10, 1'b0, 5'd4);
        step();
        chk_state("t5_rereq", 8'h10, 1'b1, 5'd4);
        core_if.i_VEC_ACK = 1'b1; step();
        core_if.i_VEC_ACK = 1'b0; step();
        step();
        chk_state("t5_done", 8'h00, 1'b0, 5'd4);

        // level mode on channel 7 with source held high
        edge_mode = 8'h7F;
        irq = 8'h80; step();
        step();
        chk_state("t6_req7", 8'h80, 1'b1, 5'd7);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t6_reset", 8'h80, 1'b0, 5'd7);
        core_if.i_VEC_ACK = 1'b0;
        irq = 8'h00; step();
        step();
        core_if.i_VEC_ACK = 1'b1; step();
        core_if.i_VEC_ACK = 1'b0; step();
        step();
        chk_state("t6_done", 8'h00, 1'b0, 5'd7);
        edge_mode = 8'hFF;

        // asynchronous reset mid-REQ, away from any clock edge
        irq = 8'h08; step();
        irq = 8'h00; step();
        chk_state("t7_req3", 8'h08, 1'b1, 5'd3);
        #2 rst_n = 1'b0;
        #1;
        chk_state("t7_async", 8'h00, 1'b0, 5'd0);
        step();
        step();
        chk_state("t7_held", 8'h00, 1'b0, 5'd0);
        rst_n = 1'b1;
        step();

        // tick gating freezes flags, edge history and FSM
        tick = 1'b0;
        irq = 8'h08; step();
        step();
        chk_state("t8_frozen", 8'h00, 1'b0, 5'd0);
        tick = 1'b1; step();
        chk_state("t8_seen", 8'h08, 1'b0, 5'd0);
        tick = 1'b0; step();
        step();
        chk_state("t8_fsmfrz", 8'h08, 1'b0, 5'd0);
        tick = 1'b1; step();
        chk_state("t8_req", 8'h08, 1'b1, 5'd3);
        core_if.i_VEC_ACK = 1'b1; step();
        chk_state("t8_ack", 8'h00, 1'b0, 5'd3);
        core_if.i_VEC_ACK = 1'b0;
        irq = 8'h00; step();
        step();
        chk_state("t8_done", 8'h00, 1'b0, 5'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ika87ad_intc.md
Name: ika87ad_intc

Overview:
- Parametrised N-channel interrupt flag bank with priority arbitration and a vector-request handshake toward the CPU core.
- Successor to the single-flag cell. Adds per-channel edge/level sense, masking, a fixed-priority encoder, and a code output.
- Keeps both acknowledge modes: auto-ack on vector fetch, and manual ack by code in multi-IRQ mode.
- Sits between the peripheral IRQ sources (timers, serial, ADC, INT pins) and the core's interrupt sequencer.

Parameters:
- NCH, 8, number of interrupt channels (1..32).
- CODEW, 5, width of the interrupt code.
- CODE_BASE, 0, code of channel 0; channel i has code CODE_BASE+i. The code must fit CODEW bits.

Ports:
- i_EMUCLK  in  1  system clock
- i_MRST_n  in  1  asynchronous active-low reset
- i_TICK  in  1  clock enable; all state updates only when high
- i_IRQ  in  NCH  raw interrupt sources
- i_EDGE_MODE  in  NCH  1 = set flag on 0→1 of source; 0 = set flag while source high
- i_MASK  in  NCH  1 = channel masked (no arbitration, no ack)
- i_INT_EN  in  1  global interrupt enable (EI state from core)
- i_MULTI_IRQ_ENABLED  in  1  1 = manual-ack mode; 0 = auto-ack mode
- i_MANUAL_ACK  in  1  manual ack strobe
- i_ACK_CODE  in  CODEW  code to be acknowledged by i_MANUAL_ACK
- i_VEC_ACK  in  1  core accepts the pending request (vector fetch)
- o_IFLAG  out  NCH  flag registers
- o_INT_REQ  out  1  request to core
- o_INT_CODE  out  CODEW  code of the requested channel, latched

Behaviour:
- Reset is asynchronous on i_MRST_n low, independent of i_TICK. On reset:
  - o_IFLAG=0, edge history=0, o_INT_REQ=0, o_INT_CODE=0, FSM=IDLE.
- Reset mid-request abandons the request with no ack side effects.
- Edge detect:
  - prev[i] <= i_IRQ[i] on every tick.
  - set[i] = EDGE_MODE[i] ? (i_IRQ[i] & ~prev[i]) : i_IRQ[i].
  - Mode change with the source high: prev already tracks the source, so no spurious set.
- Flag update per tick, in priority order:
  1. set[i] → flag=1. Set beats any same-tick clear.
  2. Otherwise, unmasked channel with i_MULTI_IRQ_ENABLED=1, i_MANUAL_ACK=1 and i_ACK_CODE==CODE_BASE+i → flag=0.
  3. Otherwise, i_MULTI_IRQ_ENABLED=0, FSM=REQ, i_VEC_ACK=1 and i == latched channel → flag=0 (auto-ack).
- Manual ack with a code matching no channel: no effect.
- In multi mode, i_VEC_ACK never clears a flag.
- Eligibility: elig = o_IFLAG & ~i_MASK. Priority is fixed; lowest index wins.
- FSM states are IDLE, REQ and HOLD. Transitions are evaluated on ticks only.
  - IDLE:
    - if i_INT_EN and elig≠0 → REQ.
    - On entry to REQ, latch chan = winner and o_INT_CODE = CODE_BASE+winner.
  - REQ:
    - o_INT_REQ=1. The code is held stable and is not pre-empted by higher-priority arrivals.
    - i_VEC_ACK → HOLD.
    - Otherwise, if elig[chan]=0 (masked or manually acked) or i_INT_EN=0 → IDLE, request withdrawn.
  - HOLD: o_INT_REQ=0 for exactly one tick, then → IDLE. This gives the core one tick to drop EI before re-arbitration.
- Latency:
  - Source edge at tick n → flag visible after tick n.
  - o_INT_REQ high after tick n+1, when enabled and winning.
- o_INT_REQ and o_INT_CODE are registered; there is no combinational path from inputs.
- o_INT_CODE keeps its last value in IDLE and HOLD.
- i_VEC_ACK outside REQ: ignored.
- i_TICK low: all registers hold, including edge history. Edges spanning a non-tick cycle are seen at the next tick.

Test Plan:
- Reset, then i_IRQ[3] pulse with EDGE_MODE[3]=1, INT_EN=1, MULTI=0:
  - o_IFLAG=0x08 after one tick, o_INT_REQ=1 with CODE=3 next tick.
  - VEC_ACK → o_IFLAG=0, REQ low for one tick, FSM IDLE.
- Flags 5 and 2 set together, unmasked: CODE=2 first. After auto-ack of 2, HOLD, then CODE=5.
- While REQ holds CODE=5, raise channel 0: CODE stays 5 until ack, then CODE=0.
- MULTI=1, flags 1 and 6, VEC_ACK on CODE=1: both flags remain.
  - MANUAL_ACK with ACK_CODE=6 → only flag 6 clears.
  - MANUAL_ACK with ACK_CODE=6 and MASK[6]=1 → flag 6 stays.
- Same tick as auto-ack, new edge on the latched channel: flag stays 1, FSM → HOLD, request re-raised after HOLD.
- Level mode with source held high: flag re-sets every tick after ack.
- Assert i_MRST_n low asynchronously mid-REQ, without a clock edge: outputs and flags 0 immediately.
- Ticks gated off (i_TICK=0): flags and FSM frozen despite source edges, until the next tick.
